// File: rtl/bus_control_unit.sv
// bus_control_unit: bus cycle sequencer with a byte prefetch queue and EU read/write access.
module bus_control_unit #(
    parameter int QUEUE_DEPTH = 8,
    parameter int WAIT_LIMIT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        readyb,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic [19:0] address_out,
    output logic [3:0]  bus_status,
    output logic        bus_upper_byte_enable,
    input  logic [15:0] ps,
    input  logic        pc_load,
    input  logic [15:0] pc_value,
    output logic [7:0]  q_data,
    output logic        q_valid,
    input  logic        q_pop,
    input  logic        suspend,
    input  logic [2:0]  eu_cmd,
    input  logic [19:0] eu_addr,
    input  logic [15:0] eu_wdata,
    input  logic        eu_word,
    output logic [15:0] eu_rdata,
    output logic        eu_done,
    output logic        eu_error
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, EU_LO, EU_HI} state_t;
    state_t state, state_nxt;

    logic          hi_pend, discard;
    logic [CW-1:0] wcnt;
    logic [15:0]   pfp, cyc_pfp;
    logic [OW-1:0] occ;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [7:0]    mem [QUEUE_DEPTH];
    logic          active, eu_state, done_ok, tmo, fin, split, is_wr, can_fetch, push, pop;
    logic [1:0]    n_push;

    assign active    = state != IDLE;
    assign eu_state  = state == EU_LO || state == EU_HI;
    assign done_ok   = active && !readyb;
    assign tmo       = active && readyb && wcnt == CW'(WAIT_LIMIT - 1);
    assign fin       = done_ok || tmo;
    assign split     = eu_word && eu_addr[0];
    assign is_wr     = eu_cmd == 3'd2 || eu_cmd == 3'd4;
    assign can_fetch = eu_cmd == 3'd0 && !suspend && !pc_load &&
                       ({1'b0, occ} + (OW+1)'(pfp[0] ? 1 : 2)) <= (OW+1)'(QUEUE_DEPTH);
    // a fetch overtaken by pc_load still completes on the bus but never reaches the queue
    assign push      = state == FETCH && done_ok && !discard && !pc_load;
    assign pop       = q_pop && occ != '0;
    assign n_push    = push ? (cyc_pfp[0] ? 2'd1 : 2'd2) : 2'd0;
    assign q_valid   = occ != '0;
    assign q_data    = mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = hi_pend ? EU_HI : (eu_cmd != 3'd0 && !eu_done) ? EU_LO : can_fetch ? FETCH : IDLE;
        else if (fin)
            state_nxt = IDLE;
    end

    always_comb begin
        address_out = state == FETCH ? {ps, 4'h0} + {4'h0, cyc_pfp} :
                      state == EU_LO ? eu_addr :
                      state == EU_HI ? eu_addr + 20'd1 : 20'hFFFF0;
        bus_status  = state == IDLE  ? 4'hF :
                      state == FETCH ? 4'b1001 :
                      eu_cmd == 3'd1 ? 4'b1001 :
                      eu_cmd == 3'd2 ? 4'b1010 :
                      eu_cmd == 3'd3 ? 4'b0001 :
                      eu_cmd == 3'd4 ? 4'b0010 : 4'hF;
        bus_upper_byte_enable = state == FETCH || (state == EU_LO && (eu_word || eu_addr[0]));
        data_out    = !(eu_state && is_wr) ? 16'h0 :
                      state == EU_HI ? {2{eu_wdata[15:8]}} :
                      (eu_word && !eu_addr[0]) ? eu_wdata : {2{eu_wdata[7:0]}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hi_pend  <= 1'b0;
            discard  <= 1'b0;
            wcnt     <= '0;
            pfp      <= '0;
            cyc_pfp  <= '0;
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            eu_done  <= 1'b0;
            eu_error <= 1'b0;
            eu_rdata <= '0;
        end else begin
            state    <= state_nxt;
            hi_pend  <= state == EU_LO && done_ok && split;
            discard  <= state == FETCH && !fin && (discard || pc_load);
            wcnt     <= (active && readyb && !tmo) ? wcnt + CW'(1) : '0;
            if (state == IDLE) cyc_pfp <= pfp;
            // a timed-out low half of a split access ends the whole access
            eu_done  <= (state == EU_LO && (tmo || (done_ok && !split))) || (state == EU_HI && fin);
            eu_error <= eu_state && tmo;
            if (state == EU_LO && done_ok && !is_wr)
                eu_rdata <= (eu_word && !eu_addr[0]) ? data_in :
                            {8'h00, eu_addr[0] ? data_in[15:8] : data_in[7:0]};
            if (state == EU_HI && done_ok && !is_wr) eu_rdata[15:8] <= data_in[7:0];
            if (pc_load) begin
                occ    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                pfp    <= pc_value;
            end else begin
                occ    <= occ + OW'(n_push) - OW'(pop);
                rd_ptr <= rd_ptr + AW'(pop);
                wr_ptr <= wr_ptr + AW'(n_push);
                pfp    <= pfp + 16'(n_push);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (cyc_pfp[0]) mem[wr_ptr] <= data_in[15:8];
            else begin
                mem[wr_ptr]         <= data_in[7:0];
                mem[wr_ptr + AW'(1)] <= data_in[15:8];
            end
        end
    end
endmodule

// File: tb/tb_bus_control_unit.sv
// tb_bus_control_unit: directed vectors and hand sequences for bus_control_unit.
module tb_bus_control_unit;
    logic        clk, reset, readyb, pc_load, q_pop, suspend, eu_word;
    logic [15:0] data_in, ps, pc_value, eu_wdata;
    logic [2:0]  eu_cmd;
    logic [19:0] eu_addr;
    logic [15:0] data_out, eu_rdata;
    logic [19:0] address_out;
    logic [3:0]  bus_status;
    logic        bus_upper_byte_enable, q_valid, eu_done, eu_error;
    logic [7:0]  q_data;
    int n_chk = 0, n_fail = 0;

    bus_control_unit dut (
        .clk(clk), .reset(reset), .readyb(readyb), .data_in(data_in), .data_out(data_out),
        .address_out(address_out), .bus_status(bus_status),
        .bus_upper_byte_enable(bus_upper_byte_enable), .ps(ps), .pc_load(pc_load),
        .pc_value(pc_value), .q_data(q_data), .q_valid(q_valid), .q_pop(q_pop),
        .suspend(suspend), .eu_cmd(eu_cmd), .eu_addr(eu_addr), .eu_wdata(eu_wdata),
        .eu_word(eu_word), .eu_rdata(eu_rdata), .eu_done(eu_done), .eu_error(eu_error)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cmd;
        logic [19:0] addr;
        logic        word;
        logic [15:0] wdata, din;
        logic [19:0] e_addr;
        logic [3:0]  e_st;
        logic        e_ube;
        logic [15:0] e_dout, e_rd;
        logic        ck_rd;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_bus(input string nm);
        int k = 0;
        do begin @(negedge clk); k++; end while (bus_status == 4'hF && k < 40);
        chk({nm, " start"}, 32'(bus_status != 4'hF), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        do begin @(negedge clk); k++; end while (!eu_done && k < 40);
        chk({nm, " done"}, 32'(eu_done), 32'd1);
    endtask

    task automatic load_pc(input logic [15:0] v);
        pc_value = v; pc_load = 1;
        @(negedge clk);
        pc_load = 0;
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] exp);
        chk({nm, " valid"}, 32'(q_valid), 32'd1);
        chk({nm, " data"}, 32'(q_data), 32'(exp));
        q_pop = 1;
        @(negedge clk);
        q_pop = 0;
    endtask

    initial begin
        int k, n;
        logic seen;
        vt[0] = '{3'd1, 20'h12344, 1'b0, 16'h0000, 16'hA55A, 20'h12344, 4'b1001, 1'b0, 16'h0000, 16'h005A, 1'b1};
        vt[1] = '{3'd1, 20'h12345, 1'b0, 16'h0000, 16'hA55A, 20'h12345, 4'b1001, 1'b1, 16'h0000, 16'h00A5, 1'b1};
        vt[2] = '{3'd1, 20'h00200, 1'b1, 16'h0000, 16'h1234, 20'h00200, 4'b1001, 1'b1, 16'h0000, 16'h1234, 1'b1};
        vt[3] = '{3'd2, 20'h00300, 1'b0, 16'h77C3, 16'h0000, 20'h00300, 4'b1010, 1'b0, 16'hC3C3, 16'h0000, 1'b0};
        vt[4] = '{3'd2, 20'h00400, 1'b1, 16'hBEEF, 16'h0000, 20'h00400, 4'b1010, 1'b1, 16'hBEEF, 16'h0000, 1'b0};
        vt[5] = '{3'd3, 20'h00061, 1'b0, 16'h0000, 16'h3C00, 20'h00061, 4'b0001, 1'b1, 16'h0000, 16'h003C, 1'b1};
        vt[6] = '{3'd4, 20'h00043, 1'b0, 16'h0011, 16'h0000, 20'h00043, 4'b0010, 1'b1, 16'h1111, 16'h0000, 1'b0};
        vt[7] = '{3'd3, 20'h00060, 1'b1, 16'h0000, 16'hCAFE, 20'h00060, 4'b0001, 1'b1, 16'h0000, 16'hCAFE, 1'b1};

        reset = 1; readyb = 0; data_in = 0; ps = 16'hF000; pc_load = 0; pc_value = 0;
        q_pop = 0; suspend = 1; eu_cmd = 0; eu_addr = 0; eu_wdata = 0; eu_word = 0;
        repeat (2) @(negedge clk);
        chk("rst addr", 32'(address_out), 32'hFFFF0);
        chk("rst status", 32'(bus_status), 32'hF);
        chk("rst ube", 32'(bus_upper_byte_enable), 32'd0);
        chk("rst dout", 32'(data_out), 32'd0);
        chk("rst done/err", 32'({eu_done, eu_error}), 32'd0);
        chk("rst rdata", 32'(eu_rdata), 32'd0);
        chk("rst qvalid", 32'(q_valid), 32'd0);
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            eu_cmd = vt[i].cmd; eu_addr = vt[i].addr; eu_word = vt[i].word;
            eu_wdata = vt[i].wdata; data_in = vt[i].din;
            wait_bus($sformatf("vec%0d", i));
            chk($sformatf("vec%0d addr", i), 32'(address_out), 32'(vt[i].e_addr));
            chk($sformatf("vec%0d status", i), 32'(bus_status), 32'(vt[i].e_st));
            chk($sformatf("vec%0d ube", i), 32'(bus_upper_byte_enable), 32'(vt[i].e_ube));
            chk($sformatf("vec%0d dout", i), 32'(data_out), 32'(vt[i].e_dout));
            wait_done($sformatf("vec%0d", i));
            if (vt[i].ck_rd) chk($sformatf("vec%0d rdata", i), 32'(eu_rdata), 32'(vt[i].e_rd));
            chk($sformatf("vec%0d err", i), 32'(eu_error), 32'd0);
            eu_cmd = 0;
            @(negedge clk);
        end

        // word fetch at even PFP
        load_pc(16'h0010);
        data_in = 16'h2211; suspend = 0;
        wait_bus("f39");
        chk("f39 addr", 32'(address_out), 32'hF0010);
        chk("f39 status", 32'(bus_status), 32'b1001);
        chk("f39 ube", 32'(bus_upper_byte_enable), 32'd1);
        suspend = 1;
        @(negedge clk);
        pop_chk("f39 b0", 8'h11);
        pop_chk("f39 b1", 8'h22);
        chk("f39 empty", 32'(q_valid), 32'd0);
        data_in = 16'h4433; suspend = 0;
        wait_bus("f39 next");
        chk("f39 next addr", 32'(address_out), 32'hF0012);
        suspend = 1;
        @(negedge clk);

        // odd PFP byte fetch, then word fetch
        load_pc(16'h0003);
        chk("f40 flushed", 32'(q_valid), 32'd0);
        data_in = 16'hAB99; suspend = 0;
        wait_bus("f40");
        chk("f40 addr", 32'(address_out), 32'hF0003);
        chk("f40 ube", 32'(bus_upper_byte_enable), 32'd1);
        @(negedge clk);
        data_in = 16'hDDCC;
        wait_bus("f40 next");
        chk("f40 next addr", 32'(address_out), 32'hF0004);
        suspend = 1;
        @(negedge clk);
        pop_chk("f40 b0", 8'hAB);
        pop_chk("f40 b1", 8'hCC);
        pop_chk("f40 b2", 8'hDD);
        chk("f40 empty", 32'(q_valid), 32'd0);

        // fill to QUEUE_DEPTH-1 at even PFP: fetch must stall until a pop
        load_pc(16'h0001);
        data_in = 16'h5A5A; suspend = 0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus_status != 4'hF) n++;
        end
        chk("f42 fetch count", 32'(n), 32'd4);
        q_pop = 1;
        @(negedge clk);
        q_pop = 0;
        wait_bus("f42 resume");
        chk("f42 resume addr", 32'(address_out), 32'hF0008);
        suspend = 1;
        @(negedge clk);
        n = 0;
        q_pop = 1;
        while (q_valid && n < 20) begin @(negedge clk); n++; end
        q_pop = 0;
        chk("f42 occupancy", 32'(n), 32'd8);

        // split word write and read at odd address
        eu_cmd = 3'd2; eu_addr = 20'h00101; eu_word = 1; eu_wdata = 16'hBEEF;
        wait_bus("s41 lo");
        chk("s41 lo addr", 32'(address_out), 32'h00101);
        chk("s41 lo status", 32'(bus_status), 32'b1010);
        chk("s41 lo ube", 32'(bus_upper_byte_enable), 32'd1);
        chk("s41 lo dout", 32'(data_out[15:8]), 32'hEF);
        wait_bus("s41 hi");
        chk("s41 hi addr", 32'(address_out), 32'h00102);
        chk("s41 hi ube", 32'(bus_upper_byte_enable), 32'd0);
        chk("s41 hi dout", 32'(data_out[7:0]), 32'hBE);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (eu_done) begin n++; eu_cmd = 0; end
        end
        chk("s41 done pulses", 32'(n), 32'd1);
        eu_cmd = 3'd1; eu_addr = 20'h00201; data_in = 16'h7700;
        wait_bus("srd lo");
        chk("srd lo addr", 32'(address_out), 32'h00201);
        @(negedge clk);
        data_in = 16'h0088;
        wait_bus("srd hi");
        chk("srd hi addr", 32'(address_out), 32'h00202);
        chk("srd hi ube", 32'(bus_upper_byte_enable), 32'd0);
        wait_done("srd");
        chk("srd rdata", 32'(eu_rdata), 32'h8877);
        chk("srd err", 32'(eu_error), 32'd0);
        eu_cmd = 0; eu_word = 0;
        @(negedge clk);

        // timeout with readyb stuck high
        readyb = 1; eu_cmd = 3'd1; eu_addr = 20'h00050;
        wait_bus("t44");
        k = 0;
        do begin @(negedge clk); k++; end while (!eu_done && k < 40);
        chk("t44 cycles", 32'(k), 32'd15);
        chk("t44 error", 32'(eu_error), 32'd1);
        chk("t44 status", 32'(bus_status), 32'hF);
        eu_cmd = 0; readyb = 0;
        @(negedge clk);
        chk("t44 done clear", 32'({eu_done, eu_error}), 32'd0);

        // pc_load during a waited fetch
        load_pc(16'h0020);
        readyb = 1; data_in = 16'h1111; suspend = 0;
        wait_bus("f43");
        chk("f43 addr", 32'(address_out), 32'hF0020);
        pc_value = 16'h0040; pc_load = 1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pc_load = 0;
            if (c == 2) readyb = 0;
            if (c == 3) data_in = 16'h2468;
            seen |= q_valid;
        end
        chk("f43 no stale push", 32'(seen), 32'd0);
        wait_bus("f43 next");
        chk("f43 next addr", 32'(address_out), 32'hF0040);
        suspend = 1;
        @(negedge clk);
        pop_chk("f43 b0", 8'h68);
        pop_chk("f43 b1", 8'h24);

        // reset mid-cycle, then first prefetch right after reset
        readyb = 1; eu_cmd = 3'd1; eu_addr = 20'h00080;
        wait_bus("r37");
        @(negedge clk);
        reset = 1; eu_cmd = 0; suspend = 0;
        @(negedge clk);
        chk("r37 status", 32'(bus_status), 32'hF);
        chk("r37 done", 32'(eu_done), 32'd0);
        chk("r37 rdata", 32'(eu_rdata), 32'd0);
        reset = 0; readyb = 0;
        @(negedge clk);
        chk("r38 fetch status", 32'(bus_status), 32'b1001);
        chk("r38 fetch addr", 32'(address_out), 32'hF0000);
        chk("r38 no done", 32'(eu_done), 32'd0);
        suspend = 1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
